sprite_compositor: RTL

Parametrised pixel compositor that merges N sprite channels (players, bombs, projectiles) and a background layer into one RGB stream for the VGA path. Each channel delivers a palette index per pixel. The block masks transparent and disabled channels, resolves a fixed priority, and looks the winner up in a writable palette. It also accumulates per-frame sprite-overlap collision flags for the game logic. It sits between the per-object sprite fetch units and the VGA DAC outputs.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/sprite_compositor_palette_rf.sv | 46 ++++
 rtl/sprite_compositor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor.
// Holds default parameters, the RGB struct and a lowest-set-bit encoder.
package sprite_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int IDX_W_DEF  = 4;
    localparam int TRANSP_DEF = 0;
    localparam int RGB_W_DEF  = 8;

    // Encoder is sized for the largest supported channel count.
    localparam int MAX_CH   = 8;
    localparam int CH_SEL_W = $clog2(MAX_CH);

    typedef struct packed {
        logic [RGB_W_DEF-1:0] r;
        logic [RGB_W_DEF-1:0] g;
        logic [RGB_W_DEF-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic                none;
        logic [CH_SEL_W-1:0] sel;
    } penc_t;

    // Lowest set bit wins; none is set when v is all zero.
    function automatic penc_t prio_enc(input logic [MAX_CH-1:0] v);
        penc_t r;
        r.none = 1'b1;
        r.sel  = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.none = 1'b0;
                r.sel  = CH_SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_compositor_palette_rf.sv
// Palette register file: one synchronous write port, one registered read.
// Ports: we/waddr/wdata write; raddr in, rdata out one cycle later (old data on collision).
module palette_rf #(
    parameter int IDX_W = 4,
    parameter int DW    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [DW-1:0]    rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read samples the current array, so a same-cycle write is not seen.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: mask, resolve priority, palette lookup.
// Ports: pixel/channel inputs, palette write port, RGB out, per-frame collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int TRANSP = TRANSP_DEF,
    parameter int RGB_W  = RGB_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    input  logic                  active,
    input  logic                  frame_start,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       ch_draw,
    input  logic [N_CH*IDX_W-1:0] ch_idx,
    input  logic [IDX_W-1:0]      bg_idx,
    input  logic                  pal_we,
    input  logic [IDX_W-1:0]      pal_waddr,
    input  logic [3*RGB_W-1:0]    pal_wdata,
    output logic [RGB_W-1:0]      red,
    output logic [RGB_W-1:0]      green,
    output logic [RGB_W-1:0]      blue,
    output logic                  rgb_valid,
    output logic [N_CH-1:0]       coll_flags,
    output logic                  coll_strobe
);

    localparam logic [IDX_W-1:0] TR = IDX_W'(TRANSP);
    localparam int DW = 3 * RGB_W;

    // stage 1
    logic                  s1_valid_q,  s1_valid_d;
    logic                  s1_active_q, s1_active_d;
    logic [N_CH-1:0]       s1_opaque_q, s1_opaque_d;
    logic [N_CH*IDX_W-1:0] s1_idx_q,    s1_idx_d;
    logic [IDX_W-1:0]      s1_bg_q,     s1_bg_d;

    // stage 2
    logic                  s2_valid_q,  s2_valid_d;
    logic                  s2_show_q,   s2_show_d;
    logic                  s2_black;
    logic [IDX_W-1:0]      s2_win_q,    s2_win_d;

    // stage 3
    logic                  s3_valid_q,  s3_valid_d;
    logic                  s3_show_q,   s3_show_d;
    logic [DW-1:0]         pal_rdata;

    // collision
    logic [N_CH-1:0]       coll_live_q,   coll_live_d;
    logic [N_CH-1:0]       coll_flags_q,  coll_flags_d;
    logic                  coll_strobe_q, coll_strobe_d;

    logic [MAX_CH-1:0]     opq_ext;
    penc_t                 pe;
    logic [IDX_W-1:0]      ch_win;
    logic                  multi;
    logic [N_CH-1:0]       hit;

    always_comb begin
        s1_valid_d  = pix_valid;
        s1_active_d = active;
        s1_idx_d    = ch_idx;
        s1_bg_d     = bg_idx;
        for (int i = 0; i < N_CH; i++) begin
            s1_opaque_d[i] = ch_en[i] & ch_draw[i]
                           & (ch_idx[i*IDX_W +: IDX_W] != TR);
        end
    end

    always_comb begin
        opq_ext = '0;
        opq_ext[N_CH-1:0] = s1_opaque_q;
        pe = prio_enc(opq_ext);

        ch_win = TR;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_SEL_W'(i) == pe.sel) begin
                ch_win = s1_idx_q[i*IDX_W +: IDX_W];
            end
        end

        // Sprite beats background; an empty pixel is black, not palette[TR].
        s2_black = 1'b0;
        if (!pe.none) begin
            s2_win_d = ch_win;
        end else if (s1_bg_q != TR) begin
            s2_win_d = s1_bg_q;
        end else begin
            s2_win_d = TR;
            s2_black = 1'b1;
        end

        s2_valid_d = s1_valid_q;
        s2_show_d  = s1_valid_q & s1_active_q & ~s2_black;

        // x & (x-1) is nonzero iff at least two bits are set.
        multi = |(s1_opaque_q & (s1_opaque_q - N_CH'(1)));
        hit   = (s1_valid_q & s1_active_q & multi) ? s1_opaque_q : '0;

        // The stage-2 pixel on a frame_start cycle opens the new frame.
        coll_live_d   = frame_start ? hit : (coll_live_q | hit);
        coll_flags_d  = frame_start ? coll_live_q : coll_flags_q;
        coll_strobe_d = frame_start;

        s3_valid_d = s2_valid_q;
        s3_show_d  = s2_show_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_active_q   <= 1'b0;
            s1_opaque_q   <= '0;
            s1_idx_q      <= '0;
            s1_bg_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_show_q     <= 1'b0;
            s2_win_q      <= '0;
            s3_valid_q    <= 1'b0;
            s3_show_q     <= 1'b0;
            coll_live_q   <= '0;
            coll_flags_q  <= '0;
            coll_strobe_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_active_q   <= s1_active_d;
            s1_opaque_q   <= s1_opaque_d;
            s1_idx_q      <= s1_idx_d;
            s1_bg_q       <= s1_bg_d;
            s2_valid_q    <= s2_valid_d;
            s2_show_q     <= s2_show_d;
            s2_win_q      <= s2_win_d;
            s3_valid_q    <= s3_valid_d;
            s3_show_q     <= s3_show_d;
            coll_live_q   <= coll_live_d;
            coll_flags_q  <= coll_flags_d;
            coll_strobe_q <= coll_strobe_d;
        end
    end

    palette_rf #(
        .IDX_W (IDX_W),
        .DW    (DW)
    ) u_pal (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (pal_we),
        .waddr   (pal_waddr),
        .wdata   (pal_wdata),
        .raddr   (s2_win_q),
        .rdata   (pal_rdata)
    );

    assign {red, green, blue} = s3_show_q ? pal_rdata : '0;
    assign rgb_valid   = s3_valid_q;
    assign coll_flags  = coll_flags_q;
    assign coll_strobe = coll_strobe_q;

endmodule
